mem_port_ctrl: RTL and testbench
================================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent in REQ waiting for bus_ack before an error.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be asynchronous, active-low (0 = reset asserted).
REQ-004 req  in  1  SHALL be the controller memory-access request, held high until done or err.
REQ-005 we  in  1  SHALL be write enable qualifying req (1 = write, 0 = read).
REQ-006 addr  in  32  SHALL be the byte address (already selected between PC and ALUOut).
REQ-007 wdata  in  32  SHALL be the write data.
REQ-008 rdata  out  32  SHALL be the registered read data.
REQ-009 done  out  1  SHALL be a one-cycle completion pulse.
REQ-010 err  out  1  SHALL be a one-cycle error pulse (misaligned address or timeout).
REQ-011 stall  out  1  SHALL tell the controller to hold its current state.
REQ-012 bus_req  out  1, bus_we  out  1, bus_addr  out  32, bus_wdata  out  32  SHALL drive the external memory bus.
REQ-013 bus_ack  in  1, bus_rdata  in  32  SHALL be the memory response; bus_rdata is valid only while bus_ack=1.

Function
REQ-014 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-015 IDLE, req=1, addr[1:0]=00: latch we/addr/wdata into bus_we/bus_addr/bus_wdata; go to REQ; clear timeout counter.
REQ-016 IDLE, req=1, addr[1:0]!=00: go to ERR; bus_req SHALL never assert for that request.
REQ-017 IDLE, req=0: remain in IDLE.
REQ-018 bus_req SHALL be 1 exactly while in REQ; bus_we/bus_addr/bus_wdata SHALL stay constant throughout REQ.
REQ-019 REQ, bus_ack=1: if bus_we=0, load bus_rdata into rdata; go to DONE.
REQ-020 REQ, bus_ack=0: increment 8-bit-or-wider counter; when the counter equals TIMEOUT, go to ERR.
REQ-021 bus_ack=1 in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-022 DONE: done=1 for that cycle only; unconditionally go to IDLE; req is ignored that cycle.
REQ-023 ERR: err=1 for that cycle only; unconditionally go to IDLE; rdata unchanged.
REQ-024 stall SHALL equal (state=REQ) or (state=IDLE and req=1); stall SHALL be 0 in DONE and ERR.
REQ-025 bus_ack in IDLE, DONE or ERR SHALL be ignored.
REQ-026 Writes SHALL never modify rdata.
REQ-027 Minimum latency: req in IDLE at cycle N, bus_ack in cycle N+1, done at N+2, rdata valid from N+2.
REQ-028 Changes on req/we/addr/wdata during REQ SHALL have no effect.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, rdata=0, done=0, err=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, counter=0, regardless of clk.
REQ-030 Reset mid-REQ SHALL drop bus_req without waiting for bus_ack; an ack arriving after reset release while in IDLE SHALL be ignored.
REQ-031 First transaction after reset release SHALL behave identically to any other.

Verification
REQ-032 Read: req=1, we=0, addr=0x0000_0010; ack one cycle after bus_req with bus_rdata=0xDEAD_BEEF -> bus_addr=0x10, done pulse 2 cycles after req, rdata=0xDEAD_BEEF, stall=1 for exactly 2 cycles.
REQ-033 Write: req=1, we=1, addr=0x20, wdata=0x1234_5678; ack after 3 wait cycles -> bus_we=1, bus_wdata=0x1234_5678 stable through REQ, done pulse, rdata unchanged.
REQ-034 Misaligned: req=1, addr=0x0000_0013 -> bus_req stays 0, err pulses next cycle, done stays 0.
REQ-035 Timeout: TIMEOUT=4, never ack -> err pulses after 4 REQ cycles, bus_req drops; repeat with ack on the 4th cycle -> done, no err.
REQ-036 Reset mid-transaction: assert reset=0 during REQ between clock edges -> bus_req=0 and stall=0 immediately; late ack after release produces no done.
REQ-037 Back-to-back: req held high across DONE -> IDLE cycle, then new request launched; two done pulses, never consecutive.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// Memory port controller: turns a held multicycle-CPU access request into a single
// bus transaction with alignment checking, ack timeout and registered read data.
module mem_port_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Counter is at least 8 bits, wider only when TIMEOUT needs it.
  localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            launch;
  logic            rd_load;

  assign cnt_inc = cnt_q + CntW'(1);

  // Next-state logic: launch aligned requests, wait for ack or timeout, then pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    rd_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (addr[1:0] == 2'b00) begin
            launch  = 1'b1;
            cnt_d   = '0;
            state_d = StReq;
          end else begin
            state_d = StErr;
          end
        end
      end
      StReq: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (bus_ack) begin
          rd_load = ~bus_we;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutCnt) state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus command registers, captured once at launch so they stay stable through REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (launch) begin
      bus_we    <= we;
      bus_addr  <= addr;
      bus_wdata <= wdata;
    end
  end

  // Read data register, written only by an acked read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rd_load) begin
      rdata <= bus_rdata;
    end
  end

  assign bus_req = (state_q == StReq);
  assign done    = (state_q == StDone);
  assign err     = (state_q == StErr);
  // Gated by reset so the controller is released the moment reset asserts.
  assign stall   = reset & ((state_q == StReq) | ((state_q == StIdle) & req));

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl (TIMEOUT=4): scoreboard of expected completions.
module tb_mem_port_ctrl;

  logic        clk, reset, req, we, bus_ack;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        done, err, stall, bus_req, bus_we;

  typedef struct packed {
    logic        d;
    logic        e;
    logic [31:0] rd;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   obs_cyc[$];
  int   cyc;
  int   n_chk, n_pass;

  mem_port_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completion monitor: records every done/err pulse with its cycle number.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done || err) begin
      obs_q.push_back('{d: done, e: err, rd: rdata});
      obs_cyc.push_back(cyc);
    end
  end

  // Drives one request, plays the memory (ack on REQ cycle ack_at, 0 = never),
  // scrambles the CPU-side inputs during REQ and records what the bus saw.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] rd, input bit hold,
                         output int n_stall, output int n_busreq, output int lat,
                         output bit stable, output logic [31:0] fa, output logic fw,
                         output logic [31:0] fwd);
    n_stall = 0; n_busreq = 0; lat = -1; stable = 1'b1; fa = '0; fw = 1'b0; fwd = '0;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = wd;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (done || err) begin
        lat = k;
        break;
      end
      if (bus_req) begin
        n_busreq++;
        if (n_busreq == 1) begin
          fa = bus_addr; fw = bus_we; fwd = bus_wdata;
        end else if (bus_addr !== fa || bus_we !== fw || bus_wdata !== fwd) begin
          stable = 1'b0;
        end
        addr = ~a; wdata = ~wd; we = ~w;
        bus_ack   = (n_busreq == ack_at);
        bus_rdata = bus_ack ? rd : $urandom;
      end else begin
        bus_ack = 1'b0;
      end
    end
    req = hold; bus_ack = 1'b0; addr = a; wdata = wd; we = w;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #1 reset = 1'b0;
    #1;
    n_chk++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req: got %b, want 0", bus_req); else n_pass++;
    n_chk++; if ({bus_we, bus_addr, bus_wdata} !== 65'd0) $display("FAIL reset_bus_cmd: got %b %h %h, want 0 0 0", bus_we, bus_addr, bus_wdata); else n_pass++;
    n_chk++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %h, want 0", rdata); else n_pass++;
    n_chk++; if ({done, err, stall} !== 3'b000) $display("FAIL reset_pulses: got %b, want 000", {done, err, stall}); else n_pass++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_chk++; if ({done, err, bus_req} !== 3'b000) $display("FAIL reset_idle: got %b, want 000", {done, err, bus_req}); else n_pass++;
  endtask

  task automatic test_read();
    int ns, nb, lat; bit st; logic [31:0] fa, fwd; logic fw; res_t o;
    exp_q.push_back('{d: 1'b1, e: 1'b0, rd: 32'hDEAD_BEEF});
    run_txn(1'b0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, ns, nb, lat, st, fa, fw, fwd);
    n_chk++; if (fa !== 32'h10) $display("FAIL read_bus_addr: got %h, want 00000010", fa); else n_pass++;
    n_chk++; if (lat !== 2) $display("FAIL read_latency: got %0d, want 2", lat); else n_pass++;
    n_chk++; if (ns !== 2) $display("FAIL read_stall_cycles: got %0d, want 2", ns); else n_pass++;
    n_chk++;
    if (obs_q.size() == 0) $display("FAIL read_result: got none, want %h", exp_q[0]);
    else begin
      o = obs_q.pop_front();
      if (o !== exp_q[0]) $display("FAIL read_result: got %h, want %h", o, exp_q[0]); else n_pass++;
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    n_chk++; if ({done, rdata} !== {1'b0, 32'hDEAD_BEEF}) $display("FAIL read_done_width: got %b %h, want 0 deadbeef", done, rdata); else n_pass++;
  endtask

  task automatic test_write();
    int ns, nb, lat; bit st; logic [31:0] fa, fwd; logic fw; res_t o;
    exp_q.push_back('{d: 1'b1, e: 1'b0, rd: 32'hDEAD_BEEF});
    run_txn(1'b1, 32'h20, 32'h1234_5678, 4, 32'hA5A5_5A5A, 1'b0, ns, nb, lat, st, fa, fw, fwd);
    n_chk++; if ({fw, fwd} !== {1'b1, 32'h1234_5678}) $display("FAIL write_bus_cmd: got %b %h, want 1 12345678", fw, fwd); else n_pass++;
    n_chk++; if (st !== 1'b1 || nb !== 4) $display("FAIL write_stable: got stable=%b cycles=%0d, want 1 4", st, nb); else n_pass++;
    n_chk++; if (lat !== 5) $display("FAIL write_latency: got %0d, want 5", lat); else n_pass++;
    n_chk++;
    if (obs_q.size() == 0) $display("FAIL write_result: got none, want %h", exp_q[0]);
    else begin
      o = obs_q.pop_front();
      if (o !== exp_q[0]) $display("FAIL write_result: got %h, want %h", o, exp_q[0]); else n_pass++;
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_misaligned();
    int ns, nb, lat; bit st; logic [31:0] fa, fwd; logic fw; res_t o;
    exp_q.push_back('{d: 1'b0, e: 1'b1, rd: 32'hDEAD_BEEF});
    run_txn(1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b0, ns, nb, lat, st, fa, fw, fwd);
    n_chk++; if (nb !== 0) $display("FAIL misaligned_bus_req: got %0d cycles, want 0", nb); else n_pass++;
    n_chk++; if (lat !== 1) $display("FAIL misaligned_latency: got %0d, want 1", lat); else n_pass++;
    n_chk++;
    if (obs_q.size() == 0) $display("FAIL misaligned_result: got none, want %h", exp_q[0]);
    else begin
      o = obs_q.pop_front();
      if (o !== exp_q[0]) $display("FAIL misaligned_result: got %h, want %h", o, exp_q[0]); else n_pass++;
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_timeout();
    int ns, nb, lat; bit st; logic [31:0] fa, fwd; logic fw; res_t o;
    exp_q.push_back('{d: 1'b0, e: 1'b1, rd: 32'hDEAD_BEEF});
    run_txn(1'b0, 32'h40, 32'h0, 0, 32'h0, 1'b0, ns, nb, lat, st, fa, fw, fwd);
    n_chk++; if (nb !== 4 || lat !== 5) $display("FAIL timeout_cycles: got req=%0d lat=%0d, want 4 5", nb, lat); else n_pass++;
    n_chk++; if (bus_req !== 1'b0) $display("FAIL timeout_bus_req: got %b, want 0", bus_req); else n_pass++;
    n_chk++;
    if (obs_q.size() == 0) $display("FAIL timeout_result: got none, want %h", exp_q[0]);
    else begin
      o = obs_q.pop_front();
      if (o !== exp_q[0]) $display("FAIL timeout_result: got %h, want %h", o, exp_q[0]); else n_pass++;
    end
    void'(exp_q.pop_front());
    exp_q.push_back('{d: 1'b1, e: 1'b0, rd: 32'hCAFE_F00D});
    run_txn(1'b0, 32'h44, 32'h0, 4, 32'hCAFE_F00D, 1'b0, ns, nb, lat, st, fa, fw, fwd);
    n_chk++; if (nb !== 4 || lat !== 5) $display("FAIL ack_at_limit_cycles: got req=%0d lat=%0d, want 4 5", nb, lat); else n_pass++;
    n_chk++;
    if (obs_q.size() == 0) $display("FAIL ack_at_limit_result: got none, want %h", exp_q[0]);
    else begin
      o = obs_q.pop_front();
      if (o !== exp_q[0]) $display("FAIL ack_at_limit_result: got %h, want %h", o, exp_q[0]); else n_pass++;
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid();
    int ns, nb, lat; bit st; logic [31:0] fa, fwd; logic fw; res_t o;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 32'h80; wdata = 32'h0;
    @(posedge clk); #1;
    n_chk++; if (bus_req !== 1'b1) $display("FAIL mid_reset_in_req: got %b, want 1", bus_req); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++; if ({bus_req, stall} !== 2'b00) $display("FAIL mid_reset_async: got %b, want 00", {bus_req, stall}); else n_pass++;
    n_chk++; if (bus_addr !== 32'h0) $display("FAIL mid_reset_addr: got %h, want 0", bus_addr); else n_pass++;
    req = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(posedge clk); @(posedge clk);
    @(negedge clk); bus_ack = 1'b0;
    n_chk++; if (rdata !== 32'h0 || bus_req !== 1'b0) $display("FAIL late_ack_state: got %h %b, want 0 0", rdata, bus_req); else n_pass++;
    n_chk++; if (obs_q.size() !== 0) $display("FAIL late_ack_pulse: got %0d completions, want 0", obs_q.size()); else n_pass++;
    exp_q.push_back('{d: 1'b1, e: 1'b0, rd: 32'h0BAD_F00D});
    run_txn(1'b0, 32'h84, 32'h0, 1, 32'h0BAD_F00D, 1'b0, ns, nb, lat, st, fa, fw, fwd);
    n_chk++; if (lat !== 2 || ns !== 2) $display("FAIL first_after_reset: got lat=%0d stall=%0d, want 2 2", lat, ns); else n_pass++;
    n_chk++;
    if (obs_q.size() == 0) $display("FAIL first_after_reset_result: got none, want %h", exp_q[0]);
    else begin
      o = obs_q.pop_front();
      if (o !== exp_q[0]) $display("FAIL first_after_reset_result: got %h, want %h", o, exp_q[0]); else n_pass++;
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back();
    int ns, nb, lat; bit st; logic [31:0] fa, fwd; logic fw; res_t o;
    exp_q.push_back('{d: 1'b1, e: 1'b0, rd: 32'h1111_2222});
    run_txn(1'b0, 32'h100, 32'h0, 1, 32'h1111_2222, 1'b1, ns, nb, lat, st, fa, fw, fwd);
    exp_q.push_back('{d: 1'b1, e: 1'b0, rd: 32'h3333_4444});
    run_txn(1'b0, 32'h104, 32'h0, 1, 32'h3333_4444, 1'b0, ns, nb, lat, st, fa, fw, fwd);
    n_chk++; if (fa !== 32'h104) $display("FAIL b2b_second_addr: got %h, want 00000104", fa); else n_pass++;
    n_chk++;
    if (obs_cyc.size() < 2) $display("FAIL b2b_gap: got %0d pulses, want 2", obs_cyc.size());
    else if (obs_cyc[obs_cyc.size()-1] - obs_cyc[obs_cyc.size()-2] !== 3)
      $display("FAIL b2b_gap: got %0d cycles, want 3", obs_cyc[obs_cyc.size()-1] - obs_cyc[obs_cyc.size()-2]);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL b2b_result%0d: got none, want %h", i, exp_q[0]);
      else begin
        o = obs_q.pop_front();
        if (o !== exp_q[0]) $display("FAIL b2b_result%0d: got %h, want %h", i, o, exp_q[0]); else n_pass++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    test_reset();
    test_read();
    test_write();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
